// File: rtl/reg_seq_pkg.sv
// rtl/reg_seq_pkg.sv - shared states and constants for the register-list sequencer
package reg_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CALC = 3'd1,
        XFER = 3'd2,
        LWR  = 3'd3,
        WB   = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam logic [3:0] PC_IDX     = 4'd15;
    localparam int         WORD_BYTES = 4;

    // Byte span covered by a list holding count registers.
    function automatic logic [6:0] list_span(input logic [4:0] count);
        return {count, 2'b00};
    endfunction

endpackage

// File: rtl/reg_list_prio.sv
// rtl/reg_list_prio.sv - lowest-set-bit encoder and popcount over a 16-bit register list
module reg_list_prio (
    input  logic [15:0] list,
    output logic [3:0]  low_idx,
    output logic        any,
    output logic [4:0]  count
);

    always_comb begin
        low_idx = 4'd0;
        count   = 5'd0;
        // Scanning downwards leaves the lowest set index as the final assignment.
        for (int i = 15; i >= 0; i--) begin
            if (list[i]) begin
                low_idx = 4'(i);
            end
            count = count + 5'(list[i]);
        end
    end

    assign any = |list;

endmodule

// File: rtl/reg_list_sequencer.sv
// rtl/reg_list_sequencer.sv - LDM/STM register-list transfer engine; base writeback under REG_SEQ_BASE_WB_EN
module reg_list_sequencer
    import reg_seq_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          is_load,
    input  logic [15:0]   reg_list,
    input  logic [AW-1:0] base,
    input  logic [3:0]    rn,
    input  logic          pre,
    input  logic          up,
    input  logic          wb,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,
    output logic [3:0]    r_addr,
    input  logic [DW-1:0] r_data,
    output logic [3:0]    w_addr,
    output logic [DW-1:0] w_data,
    output logic          write_reg,
    output logic          write_pc,
    output logic [DW-1:0] pc_data
);

    state_t        state_q, state_d;
    logic          is_load_q, is_load_d;
    logic          pre_q, pre_d;
    logic          up_q, up_d;
    logic          err_q, err_d;
    logic [15:0]   list_q, list_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    cur_q, cur_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic [3:0]    low_idx;
    logic          any_left;
    logic [4:0]    count;
    logic [AW-1:0] span;
    logic [AW-1:0] word;

    reg_list_prio u_prio (
        .list    (list_q),
        .low_idx (low_idx),
        .any     (any_left),
        .count   (count)
    );

    assign span = AW'(list_span(count));
    assign word = AW'(WORD_BYTES);

`ifdef REG_SEQ_BASE_WB_EN
    logic [3:0]    rn_q, rn_d;
    logic [AW-1:0] fin_q, fin_d;
    logic          wb_go_q, wb_go_d;

    // A loaded Rn wins over the written-back address, so the decision is made at accept.
    always_comb begin
        rn_d    = rn_q;
        fin_d   = fin_q;
        wb_go_d = wb_go_q;
        if (state_q == IDLE && start) begin
            rn_d    = rn;
            wb_go_d = wb && !(is_load && reg_list[rn]);
        end
        if (state_q == CALC) begin
            fin_d = up_q ? addr_q + span : addr_q - span;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rn_q    <= 4'd0;
            fin_q   <= '0;
            wb_go_q <= 1'b0;
        end else begin
            rn_q    <= rn_d;
            fin_q   <= fin_d;
            wb_go_q <= wb_go_d;
        end
    end
`else
    logic unused_wb_cmd;
    assign unused_wb_cmd = ^{wb, rn};
`endif

    always_comb begin
        state_d   = state_q;
        is_load_d = is_load_q;
        pre_d     = pre_q;
        up_d      = up_q;
        err_d     = err_q;
        list_d    = list_q;
        addr_d    = addr_q;
        cur_d     = cur_q;
        rdata_d   = rdata_q;

        busy      = (state_q != IDLE);
        done      = 1'b0;
        err       = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        r_addr    = 4'd0;
        w_addr    = 4'd0;
        w_data    = '0;
        write_reg = 1'b0;
        write_pc  = 1'b0;
        pc_data   = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    is_load_d = is_load;
                    pre_d     = pre;
                    up_d      = up;
                    list_d    = reg_list;
                    addr_d    = base;
                    err_d     = 1'b0;
                    state_d   = CALC;
                end
            end
            CALC: begin
                if (count == 5'd0) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    // Beats always climb, so descending modes start at the bottom of the block.
                    if (up_q) begin
                        addr_d = pre_q ? addr_q + word : addr_q;
                    end else begin
                        addr_d = pre_q ? addr_q - span : addr_q - span + word;
                    end
                    state_d = XFER;
                end
            end
            XFER: begin
                if (!any_left) begin
`ifdef REG_SEQ_BASE_WB_EN
                    state_d = wb_go_q ? WB : DONE;
`else
                    state_d = DONE;
`endif
                end else begin
                    mem_req  = 1'b1;
                    mem_we   = !is_load_q;
                    mem_addr = addr_q;
                    if (!is_load_q) begin
                        r_addr    = low_idx;
                        mem_wdata = r_data;
                    end
                    if (mem_ready) begin
                        list_d[low_idx] = 1'b0;
                        addr_d          = addr_q + word;
                        cur_d           = low_idx;
                        rdata_d         = mem_rdata;
                        if (is_load_q) begin
                            state_d = LWR;
                        end
                    end
                end
            end
            LWR: begin
                if (cur_q == PC_IDX) begin
                    write_pc = 1'b1;
                    pc_data  = {rdata_q[DW-1:2], 2'b00};
                end else begin
                    write_reg = 1'b1;
                    w_addr    = cur_q;
                    w_data    = rdata_q;
                end
                state_d = XFER;
            end
`ifdef REG_SEQ_BASE_WB_EN
            WB: begin
                write_reg = 1'b1;
                w_addr    = rn_q;
                w_data    = fin_q;
                state_d   = DONE;
            end
`endif
            DONE: begin
                done    = 1'b1;
                err     = err_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            is_load_q <= 1'b0;
            pre_q     <= 1'b0;
            up_q      <= 1'b0;
            err_q     <= 1'b0;
            list_q    <= 16'd0;
            addr_q    <= '0;
            cur_q     <= 4'd0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            is_load_q <= is_load_d;
            pre_q     <= pre_d;
            up_q      <= up_d;
            err_q     <= err_d;
            list_q    <= list_d;
            addr_q    <= addr_d;
            cur_q     <= cur_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: doc/reg_list_sequencer.md
Name: reg_list_sequencer

Overview:
- Multi-register transfer engine (LDM/STM class) for the ARM-style core.
- Walks a 16-bit register list and issues one memory beat per set bit.
- Load direction: drives the banked register file's write port (w_addr/w_data/write_reg) and its PC port (write_pc/pc_data).
- Store direction: drives one register-file read port (r_addr), takes r_data back, and forwards it to memory. Base-register writeback is optional.

Parameters:
- AW, 32, memory address width
- DW, 32, data width

Ports:
- clk  in  1  system clock; all state advances on posedge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle command strobe; accepted only in IDLE
- is_load  in  1  1 = load (mem->regs), 0 = store (regs->mem)
- reg_list  in  16  bit i set = transfer Ri
- base  in  AW  value of base register Rn
- rn  in  4  base register index
- pre  in  1  1 = before (IB/DB), 0 = after (IA/DA)
- up  in  1  1 = increment, 0 = decrement
- wb  in  1  write final address back to Rn
- busy  out  1  high from accept to done
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done when reg_list == 0
- mem_req  out  1  memory request
- mem_we  out  1  1 = write beat
- mem_addr  out  AW  word address of current beat
- mem_wdata  out  DW  store data
- mem_ready  in  1  beat accepted; sampled on posedge
- mem_rdata  in  DW  load data, valid when mem_ready
- r_addr  out  4  register-file read address (store)
- r_data  in  DW  register-file read data, same-cycle
- w_addr  out  4  register-file write address
- w_data  out  DW  register-file write data
- write_reg  out  1  register write strobe (one cycle)
- write_pc  out  1  PC write strobe (one cycle)
- pc_data  out  DW  PC write value

Behaviour:
- Reset: all outputs 0; state IDLE; command registers cleared. Reset mid-transfer aborts at once, with no further strobes.
- States: IDLE -> CALC -> XFER -> (LWR) -> ... -> WB -> DONE -> IDLE.
- IDLE: on start, latch all command inputs, set busy, go to CALC. start while busy is ignored.
- CALC (1 cycle):
  - n = popcount(reg_list).
  - Start address: IA = base; IB = base+4; DA = base-4n+4; DB = base-4n.
  - Final address: base+4n when up, else base-4n. Arithmetic is modulo 2^AW; wrap is not flagged.
  - n == 0: go to DONE with err.
- XFER:
  - mem_req = 1, mem_addr = current address, cur = lowest remaining set bit.
  - Store: r_addr = cur, mem_wdata = r_data, mem_we = 1.
  - mem_addr, mem_we and r_addr are held stable until mem_ready.
  - On mem_ready, clear bit cur and add 4 to the address.
  - Lowest-numbered register always maps to the lowest address.
- LWR (load only, the cycle after mem_ready):
  - Issue the write with mem_req low.
  - cur != 15: write_reg = 1, w_addr = cur, w_data = captured rdata.
  - cur == 15: write_pc = 1, pc_data = rdata & ~3, write_reg = 0.
  - Load latency: 1 cycle from ready to register strobe. Next beat starts the following cycle.
- After the last beat: go to WB if writeback is enabled and wb = 1, else to DONE.
- WB (1 cycle): write_reg = 1, w_addr = rn, w_data = final address. Skipped when is_load and reg_list[rn] = 1; the loaded value wins.
- DONE: done = 1 for one cycle, busy drops, return to IDLE.
- mem_ready outside XFER is ignored.
- Store of R15: r_data is passed through unmodified.
- The register file writes on negedge clk, so strobes are one cycle long and centred on posedge-launched data.

Optional Feature:
- Macro: REG_SEQ_BASE_WB_EN.
- Defined: WB state and base writeback exist as described.
- Undefined: wb is ignored, WB state is removed, and Rn is never written except by the list itself.

Decomposition:
- Shared package reg_seq_pkg: state enum (IDLE, CALC, XFER, LWR, WB, DONE), PC_IDX = 4'd15, WORD_BYTES = 4.
- One sub-module: reg_list_prio, a combinational lowest-set-bit encoder plus popcount over 16 bits, instantiated once.

Test Plan:
- LDM IA, base 0x100, list 0x0006, mem_ready every cycle:
  - Reads at 0x100 then 0x104.
  - write_reg to R1 then R2 with the returned data.
  - done 7 cycles after start.
- STM DB, base 0x200, wb = 1, rn = 13, list 0x4010:
  - Writes R4 at 0x1F8 and R14 at 0x1FC.
  - WB writes R13 = 0x1F8.
- LDM IB, list 0x8001, mem_rdata 0x0000_1003 on the second beat:
  - Beats at base+4 and base+8.
  - write_pc with pc_data 0x0000_1000; no write_reg for R15.
- reg_list = 0 -> no mem_req; done and err pulse together 2 cycles after start.
- mem_ready held low 5 cycles on beat 2 -> mem_addr/r_addr stable throughout; start pulsed mid-transfer is ignored.
- LDM with wb = 1 and Rn in list -> no WB write. rst asserted during XFER -> all outputs 0 immediately and IDLE on release.
